gray_monitor: RTL and testbench
===============================

GRAY_MONITOR -- requirements
Module: gray_monitor

Interface
REQ-001 Parameter WIDTH, default 3: width of the gray-code input and the binary output.
REQ-002 Parameter CNT_WIDTH, default 4: width of the wrap counter.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Valid  input  1  GrayIn is sampled on this edge when high.
REQ-007 GrayIn  input  WIDTH  gray-coded count from an upstream gray counter.
REQ-008 Binary  output  WIDTH  binary value of the last accepted gray code, registered.
REQ-009 Wrap  output  1  one-cycle pulse when an accepted step goes from binary all-ones to 0.
REQ-010 WrapCount  output  CNT_WIDTH  number of wraps seen since reset, saturating.
REQ-011 Locked  output  1  high once a first sample has been accepted and no fault has occurred.
REQ-012 Error  output  1  sticky flag for an illegal sequence step.

Function
REQ-013 Decode SHALL be: b[W-1] = g[W-1]; b[i] = b[i+1] XOR g[i] for i = W-2 down to 0.
REQ-014 All outputs SHALL be registered, with 1-cycle latency from the sampling edge to the output update.
REQ-015 The state machine SHALL have three states: IDLE, TRACK and FAULT.
REQ-016 IDLE, Valid=1:
  - Binary <= decode(GrayIn); the raw gray value is stored.
  - Locked <= 1; Wrap stays 0.
  - Next state is TRACK.
REQ-017 IDLE, Valid=0: all outputs hold; the block stays in IDLE.
REQ-018 TRACK, Valid=1, GrayIn equal to the stored gray value (hold step): no change, no Wrap, no Error.
REQ-019 TRACK, Valid=1, legal step: GrayIn differs from the stored value in exactly one bit and decode(GrayIn) = (Binary+1) mod 2^WIDTH.
  - Binary and the stored gray value update.
  - If the old Binary was all-ones, Wrap = 1 for one cycle.
  - If the old Binary was all-ones, WrapCount increments and saturates at all-ones (no rollover).
REQ-020 TRACK, Valid=1, any other GrayIn (multi-bit change or backward step):
  - Error <= 1; Locked <= 0.
  - Binary holds the last good value; no Wrap.
  - Next state is FAULT.
REQ-021 TRACK, Valid=0: all outputs hold, Wrap = 0.
REQ-022 FAULT SHALL ignore Valid and GrayIn, hold Binary and WrapCount, and keep Error = 1 and Wrap = 0 until Reset.
REQ-023 Wrap SHALL never be high for two consecutive cycles unless two consecutive accepted steps both wrap; this is impossible for WIDTH >= 2.

Reset
REQ-024 While Reset = 1 at a clock edge, the block SHALL set state IDLE, Binary = 0, Wrap = 0, WrapCount = 0, Locked = 0, Error = 0, stored gray = 0.
REQ-025 Reset SHALL take priority over Valid on the same edge; the GrayIn presented on that edge is discarded.
REQ-026 Reset mid-sequence SHALL behave as REQ-024; the next Valid sample re-enters TRACK through IDLE with no legality check against earlier data.
REQ-027 Before the first Reset, outputs are undefined; the bench SHALL apply Reset first.

Verification
REQ-028 Reset, then Valid=1 for 9 edges with GrayIn 000,001,011,010,110,111,101,100,000 -> Binary 0..7 then 0, Wrap=1 for exactly the cycle after the 9th sample, WrapCount=1, Error=0, Locked=1.
REQ-029 In TRACK at GrayIn=011, deassert Valid for 3 cycles with GrayIn=110, then present 010 with Valid=1 -> Binary holds 2 during the gap, then becomes 3, Error=0.
REQ-030 In TRACK at Binary=2 (GrayIn 011), present GrayIn=101 -> Error=1, Locked=0, Binary stays 2; further legal codes leave Error=1 and Binary unchanged.
REQ-031 In TRACK at Binary=3 (GrayIn 010), present 011 (backward step) -> Error=1, state FAULT.
REQ-032 Drive 16 full cycles (128 legal steps) -> WrapCount saturates at 15, with Wrap pulsing on all 16 wraps.
REQ-033 Assert Reset and Valid together mid-count with GrayIn=111 -> Binary=0, WrapCount=0, Locked=0 next cycle; then Valid with GrayIn=101 -> Binary=6, Locked=1, Error=0.

Source files
------------

// File: rtl/gray_monitor.sv
// gray_monitor: decodes a gray-coded count, checks every step is +1 and tracks wraps.
// Ports:
//   Clk       rising-edge clock for all state
//   Reset     synchronous active-high reset
//   Valid     GrayIn is sampled on this edge when high
//   GrayIn    gray-coded count from an upstream gray counter
//   Binary    binary value of the last accepted gray code
//   Wrap      one-cycle pulse when an accepted step goes from all-ones to 0
//   WrapCount saturating count of wraps since reset
//   Locked    a first sample was accepted and no fault has occurred
//   Error     sticky flag for an illegal step
module gray_monitor #(
    parameter int WIDTH     = 3,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Valid,
    input  logic [WIDTH-1:0]     GrayIn,
    output logic [WIDTH-1:0]     Binary,
    output logic                 Wrap,
    output logic [CNT_WIDTH-1:0] WrapCount,
    output logic                 Locked,
    output logic                 Error
);
    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;
    state_t               state, state_n;
    logic [WIDTH-1:0]     gray_q, gray_n, bin_n, dec, bin_inc, diff;
    logic [CNT_WIDTH-1:0] cnt_n;
    logic                 wrap_n, locked_n, err_n, legal, at_max;
    // Each binary bit is the parity of the gray bits at and above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        assign dec[i] = ^GrayIn[WIDTH-1:i];
    end
    assign bin_inc = Binary + WIDTH'(1);
    assign diff    = GrayIn ^ gray_q;
    assign at_max  = &Binary;
    // Exactly one flipped bit and a forward step of one.
    assign legal   = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0) && (dec == bin_inc);
    always_comb begin
        state_n  = state;
        bin_n    = Binary;
        gray_n   = gray_q;
        wrap_n   = 1'b0;
        cnt_n    = WrapCount;
        locked_n = Locked;
        err_n    = Error;
        case (state)
            IDLE: begin
                if (Valid) begin
                    bin_n    = dec;
                    gray_n   = GrayIn;
                    locked_n = 1'b1;
                    state_n  = TRACK;
                end
            end
            TRACK: begin
                if (Valid && diff != '0) begin
                    if (legal) begin
                        bin_n  = dec;
                        gray_n = GrayIn;
                        wrap_n = at_max;
                        cnt_n  = (at_max && !(&WrapCount)) ? WrapCount + CNT_WIDTH'(1) : WrapCount;
                    end else begin
                        err_n    = 1'b1;
                        locked_n = 1'b0;
                        state_n  = FAULT;
                    end
                end
            end
            FAULT: err_n = 1'b1;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            Binary    <= '0;
            gray_q    <= '0;
            Wrap      <= 1'b0;
            WrapCount <= '0;
            Locked    <= 1'b0;
            Error     <= 1'b0;
        end else begin
            state     <= state_n;
            Binary    <= bin_n;
            gray_q    <= gray_n;
            Wrap      <= wrap_n;
            WrapCount <= cnt_n;
            Locked    <= locked_n;
            Error     <= err_n;
        end
    end
endmodule

// File: tb/tb_gray_monitor.sv
// tb_gray_monitor: directed and random stimulus checked against a behavioural model of gray_monitor.
module tb_gray_monitor;
    localparam int W  = 3;
    localparam int CW = 4;
    localparam int MAXB = (1 << W) - 1;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid = 1'b0;
    logic [W-1:0]  gray = '0;
    logic [W-1:0]  binary;
    logic          wrap;
    logic [CW-1:0] wrap_count;
    logic          locked;
    logic          error;

    int tests = 0;
    int fails = 0;

    gray_monitor #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .Clk(clk), .Reset(rst), .Valid(valid), .GrayIn(gray),
        .Binary(binary), .Wrap(wrap), .WrapCount(wrap_count),
        .Locked(locked), .Error(error)
    );

    always #5 clk = ~clk;

    function automatic int b2g(input int b);
        return b ^ (b >> 1);
    endfunction

    // Inverse of b2g found by search over the code space.
    function automatic int g2b(input int g);
        for (int b = 0; b <= MAXB; b++) if (b2g(b) == g) return b;
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: m_started = a first sample was taken, m_fault = illegal step seen.
    int m_bin = 0, m_gray = 0, m_cnt = 0;
    bit m_wrap = 0, m_locked = 0, m_err = 0, m_started = 0, m_fault = 0, m_ready = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_bin <= 0; m_gray <= 0; m_wrap <= 0; m_cnt <= 0;
            m_locked <= 0; m_err <= 0; m_started <= 0; m_fault <= 0; m_ready <= 1;
        end else begin
            m_wrap <= 0;
            if (!m_fault && valid) begin
                if (!m_started) begin
                    m_bin <= g2b(int'(gray)); m_gray <= int'(gray);
                    m_locked <= 1; m_started <= 1;
                end else if (int'(gray) == m_gray) begin
                end else if (g2b(int'(gray)) == (m_bin + 1) % (MAXB + 1)
                             && $countones(int'(gray) ^ m_gray) == 1) begin
                    m_bin <= g2b(int'(gray)); m_gray <= int'(gray);
                    if (m_bin == MAXB) begin
                        m_wrap <= 1;
                        m_cnt <= (m_cnt == MAXC) ? MAXC : m_cnt + 1;
                    end
                end else begin
                    m_err <= 1; m_locked <= 0; m_fault <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("binary", int'(binary), m_bin);
            chk("wrap", int'(wrap), int'(m_wrap));
            chk("wrap_count", int'(wrap_count), m_cnt);
            chk("locked", int'(locked), int'(m_locked));
            chk("error", int'(error), int'(m_err));
        end
    end

    task automatic step(input bit r, input bit v, input int g);
        @(negedge clk);
        rst = r; valid = v; gray = W'(g);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0);
        step(0, 0, 0);
    endtask

    int seq[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
    int wraps;
    int nb;

    initial begin
        do_reset();
        chk("rst_binary", int'(binary), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_wrap_count", int'(wrap_count), 0);

        // Full cycle through all codes and back to zero.
        for (int i = 0; i < 9; i++) begin
            step(0, 1, seq[i]);
            chk("seq_binary", int'(binary), i % 8);
            chk("seq_wrap", int'(wrap), (i == 8) ? 1 : 0);
        end
        chk("seq_wrap_count", int'(wrap_count), 1);
        chk("seq_locked", int'(locked), 1);
        chk("seq_error", int'(error), 0);
        step(0, 0, 0);
        chk("seq_wrap_drop", int'(wrap), 0);

        // Valid gap with garbage on GrayIn.
        do_reset();
        step(0, 1, 0); step(0, 1, 1); step(0, 1, 3);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 6);
            chk("gap_binary", int'(binary), 2);
        end
        step(0, 1, 2);
        chk("gap_resume", int'(binary), 3);
        chk("gap_error", int'(error), 0);

        // Multi-bit jump.
        do_reset();
        step(0, 1, 0); step(0, 1, 1); step(0, 1, 3);
        step(0, 1, 5);
        chk("jump_error", int'(error), 1);
        chk("jump_locked", int'(locked), 0);
        chk("jump_binary", int'(binary), 2);
        step(0, 1, 2); step(0, 1, 6);
        chk("fault_binary", int'(binary), 2);
        chk("fault_error", int'(error), 1);

        // Backward step.
        do_reset();
        step(0, 1, 0); step(0, 1, 1); step(0, 1, 3); step(0, 1, 2);
        step(0, 1, 3);
        chk("back_error", int'(error), 1);
        step(0, 1, 6);
        chk("back_binary", int'(binary), 3);

        // Saturation over 16 wraps.
        do_reset();
        wraps = 0;
        for (int k = 0; k <= 128; k++) begin
            step(0, 1, b2g(k % 8));
            if (wrap) wraps++;
        end
        chk("sat_wraps", wraps, 16);
        chk("sat_wrap_count", int'(wrap_count), 15);

        // Reset beats Valid on the same edge.
        do_reset();
        for (int k = 0; k < 10; k++) step(0, 1, b2g(k % 8));
        step(1, 1, 7);
        chk("rv_binary", int'(binary), 0);
        chk("rv_wrap_count", int'(wrap_count), 0);
        chk("rv_locked", int'(locked), 0);
        step(0, 1, 5);
        chk("rv_rebinary", int'(binary), 6);
        chk("rv_relocked", int'(locked), 1);
        chk("rv_reerror", int'(error), 0);

        // Random traffic, mostly legal steps.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            nb = (m_bin + 1) % (MAXB + 1);
            if (r < 3) step(1, $urandom_range(0, 1), $urandom_range(0, MAXB));
            else if (r < 73) step(0, 1, m_started ? b2g(nb) : $urandom_range(0, MAXB));
            else if (r < 85) step(0, 0, $urandom_range(0, MAXB));
            else if (r < 95) step(0, 1, m_gray);
            else step(0, 1, $urandom_range(0, MAXB));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
